// File: rtl/alu_issue.sv
// alu_issue: decodes MIPS R/I-type ALU instructions into a 2-entry skid buffer that feeds the ALU.
// Optional build macro ALU_ISSUE_ZERO_SQUASH_EN drops legal writes to r0. Rev 1.0
`default_nettype none

module alu_issue #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [31:0]          rs_val,
  input  logic [31:0]          rt_val,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [5:0]           op_aluc,
  output logic [31:0]          op_a,
  output logic [31:0]          op_b,
  output logic [4:0]           op_dest,
  output logic                 op_wr,
  output logic                 err_illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  localparam int E_W = 76;  // {aluc, a, b, dest, wr}

  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic        d_legal, d_wr, squash;
  logic [5:0]  d_aluc;
  logic [31:0] d_a, d_b;
  logic [4:0]  d_dest;
  logic [E_W-1:0] new_entry;

  logic [E_W-1:0]       slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]           count_q, count_d;
  logic                 live_q;
  logic                 err_q, err_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic                 accept, push, pop;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  always_comb begin
    d_legal = 1'b0;
    d_aluc  = funct;
    d_a     = rs_val;
    d_b     = rt_val;
    d_dest  = instr[15:11];
    d_wr    = 1'b1;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07: d_legal = 1'b1;
        6'h00, 6'h02, 6'h03: begin
          d_legal = 1'b1;
          d_a     = {27'b0, instr[10:6]};
        end
        6'h08: begin
          d_legal = 1'b1;
          d_b     = 32'b0;
          d_dest  = 5'd0;
          d_wr    = 1'b0;
        end
        default: d_legal = 1'b0;
      endcase
    end else begin
      d_dest  = instr[20:16];
      d_legal = 1'b1;
      d_b     = {{16{imm[15]}}, imm};
      case (opcode)
        6'h08: d_aluc = 6'h20;
        6'h09: d_aluc = 6'h21;
        6'h0A: d_aluc = 6'h2A;
        6'h0B: d_aluc = 6'h2B;
        6'h0C: begin d_aluc = 6'h24; d_b = {16'b0, imm}; end
        6'h0D: begin d_aluc = 6'h25; d_b = {16'b0, imm}; end
        6'h0E: begin d_aluc = 6'h26; d_b = {16'b0, imm}; end
        6'h0F: begin
          d_aluc = 6'h0F;
          d_a    = {16'b0, imm};
          d_b    = 32'b0;
        end
        default: d_legal = 1'b0;
      endcase
    end
  end

`ifdef ALU_ISSUE_ZERO_SQUASH_EN
  assign squash = d_legal && d_wr && (d_dest == 5'd0);
`else
  assign squash = 1'b0;
`endif

  assign new_entry = {d_aluc, d_a, d_b, d_dest, d_wr};

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready = live_q && (count_q != 2'd2);
  assign op_valid = (count_q != 2'd0);
  assign accept   = in_valid && in_ready;
  assign push     = accept && d_legal && !squash;
  assign pop      = op_valid && op_ready;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (push && pop) begin
      slot0_d = new_entry;
    end else if (pop) begin
      slot0_d = slot1_q;
      count_d = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) slot0_d = new_entry;
      else                 slot1_d = new_entry;
      count_d = count_q + 2'd1;
    end
  end

  always_comb begin
    err_d     = accept && !d_legal;
    ill_cnt_d = ill_cnt_q;
    if (err_d && (ill_cnt_q != {ILL_CNT_W{1'b1}}))
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q   <= '0;
      slot1_q   <= '0;
      count_q   <= 2'd0;
      live_q    <= 1'b0;
      err_q     <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      count_q   <= count_d;
      live_q    <= 1'b1;
      err_q     <= err_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign {op_aluc, op_a, op_b, op_dest, op_wr} = slot0_q;
  assign err_illegal = err_q;
  assign ill_cnt     = ill_cnt_q;

endmodule

`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

ALU issue stage: accepts decoded-register-read MIPS instructions (instruction word plus rs/rt values) over a valid/ready handshake and converts them into ALU operations (6-bit `aluc`, operands `a`/`b`, destination). It is the producer side of the ALU operand interface, sitting between register read and the ALU. A 2-entry skid buffer decouples upstream from ALU back-pressure. Illegal encodings are dropped and counted.

## Interface
- `ILL_CNT_W`, default 8: width of the saturating illegal-instruction counter.
- `clk  input  1`: clock; all state updates on the rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `in_valid  input  1`: upstream presents an instruction.
- `in_ready  output  1`: stage can accept; a transfer occurs when `in_valid && in_ready`.
- `instr  input  32`: MIPS instruction word.
- `rs_val  input  32`: value of register `instr[25:21]`.
- `rt_val  input  32`: value of register `instr[20:16]`.
- `op_valid  output  1`: ALU operation present at the buffer head.
- `op_ready  input  1`: ALU consumes; a transfer occurs when `op_valid && op_ready`.
- `op_aluc  output  6`: ALU opcode.
- `op_a  output  32`: ALU operand a.
- `op_b  output  32`: ALU operand b.
- `op_dest  output  5`: destination register.
- `op_wr  output  1`: result is written back (0 for JR).
- `err_illegal  output  1`: one-cycle pulse, registered, in the cycle after an illegal instruction is accepted.
- `ill_cnt  output  ILL_CNT_W`: saturating count of illegal instructions.

## Operation
- R-type (`instr[31:26]==0`): `op_aluc = funct` for funct ∈ {100000–100111, 101010, 101011, 000000, 000010, 000011, 000100, 000110, 000111, 001000}. `op_dest=rd`, `op_wr=1`.
  - SLL/SRL/SRA (000000/000010/000011): `a = {27'b0, shamt}`, `b = rt_val`.
  - SLLV/SRLV/SRAV: `a = rs_val`, `b = rt_val`.
  - Arithmetic, logic and set ops: `a = rs_val`, `b = rt_val`.
  - JR (001000): `a = rs_val`, `b = 0`, `op_dest = 0`, `op_wr = 0`.
- I-type: `a = rs_val`, `op_dest = rt`, `op_wr = 1`.
  - ADDI→100000, ADDIU→100001, SLTI→101010 and SLTIU→101011 use a sign-extended immediate as `b`.
  - ANDI→100100, ORI→100101 and XORI→100110 use a zero-extended immediate as `b`.
  - LUI (001111): `aluc = 001111`, `a = {16'b0, imm}`, `b = 0`.
- Illegal instructions (any other opcode or funct):
  - Accepted, not enqueued.
  - Raise `err_illegal` and increment `ill_cnt`, saturating at all-ones.
- Buffer: 2 entries, FIFO order preserved. Decode happens before enqueue; stored entries are already decoded.
- `in_ready = (count != 2)`, derived from registered state only, with no combinational path from `op_ready`.

## Timing
- Reset (async assert, sync release), everything low or zero:
  - `count = 0`
  - `op_valid = 0`
  - `op_aluc`, `op_a`, `op_b`, `op_dest`, `op_wr` = 0
  - `err_illegal = 0`
  - `ill_cnt = 0`
  - `in_ready = 0` while `rst_n` is low; `in_ready = 1` from the first edge after release.
- Latency: an instruction accepted at edge N with an empty buffer is presented on `op_*` after edge N, i.e. 1 cycle.
- Flow cases:
  - Accept with count 1 and no pop: count becomes 2 and `in_ready` drops the next cycle.
  - Simultaneous accept and pop at count 1: count stays 1; the head advances to the new entry.
  - Pop with count 2: `in_ready` rises the next cycle.
- `op_*` are held stable while `op_valid && !op_ready`.
- An illegal accept together with a pop behaves as a pop only.
- Reset mid-operation discards all buffered entries.

## Configuration
- `ALU_ISSUE_ZERO_SQUASH_EN`
  - Defined: a legal instruction with `op_wr = 1` and `op_dest = 0` (including NOP `0x00000000`) is accepted and dropped, not enqueued. It does not count as illegal.
  - Undefined: such instructions are issued normally.

## Test plan
- Reset, then ADD with `instr=0x012A4020`, `rs=5`, `rt=7` → next cycle `op_valid=1`, `aluc=0x20`, `a=5`, `b=7`, `dest=8`, `wr=1`.
- SRA with `instr=0x00094103` (shamt 4), `rt=0x80000000` → `aluc=0x03`, `a=4`, `b=0x80000000`, `dest=8`.
- ADDI with `instr=0x2128FFFF` and SLTIU with imm 0xFFFF → `b=0xFFFFFFFF`; ORI with imm 0xFFFF → `b=0x0000FFFF`; LUI with `instr=0x3C081234` → `aluc=0x0F`, `a=0x1234`, `b=0`.
- Hold `op_ready=0` and push 3 instructions → `in_ready` low after 2 accepted; release → outputs appear in order and `in_ready` returns.
- Illegal `instr=0xFC000000` three times → three `err_illegal` pulses, `ill_cnt=3`, `op_valid` stays 0. Drive 300 illegals → `ill_cnt=255`.
- Assert `rst_n` with 2 entries buffered → `op_valid=0` and `count=0` immediately. With the macro defined, `0x00000000` yields no output; with it undefined, `aluc=0x00`, `dest=0`.
